// File: rtl/csma_backoff_pkg.sv
// Shared definitions for the CSMA backoff block: state codes, settings-bus
// register offsets and the LFSR feedback taps.
package csma_backoff_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StDefer   = 2'd1,
        StBackoff = 2'd2,
        StGrant   = 2'd3
    } state_e;

    localparam logic [7:0] RegCtrl   = 8'd0;
    localparam logic [7:0] RegTiming = 8'd1;
    localparam logic [7:0] RegCw     = 8'd2;

    // Right-shifting Fibonacci form: taps 16,14,13,11 sit at bits 0,2,3,5.
    localparam logic [15:0] LfsrTaps = 16'h002D;

    function automatic logic [15:0] cw_mask(input logic [3:0] cw);
        return (16'd1 << cw) - 16'd1;
    endfunction

endpackage

// File: rtl/csma_backoff_if.sv
// Settings bus plus transmit handshake between the framer/carrier-sense
// stages and the backoff arbiter.
interface csma_backoff_if;
    logic        set_stb_user;
    logic [7:0]  set_addr_user;
    logic [31:0] set_data_user;
    logic        present;
    logic        tx_req;
    logic        tx_done;
    logic        tx_ok;
    logic        tx_grant;
    logic        tx_drop;
    logic [1:0]  state_out;

    modport master (
        output set_stb_user, set_addr_user, set_data_user,
        output present, tx_req, tx_done, tx_ok,
        input  tx_grant, tx_drop, state_out
    );

    modport slave (
        input  set_stb_user, set_addr_user, set_data_user,
        input  present, tx_req, tx_done, tx_ok,
        output tx_grant, tx_drop, state_out
    );
endinterface

// File: rtl/csma_lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR; free-running, loads seed on reset.
module csma_lfsr16
    import csma_backoff_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = {^(value_q & LfsrTaps), value_q[15:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= seed;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/csma_backoff.sv
// CSMA/CA transmit arbiter: inter-frame deferral, slotted random backoff with
// binary-exponential contention window, and retry/drop handling.
module csma_backoff
    import csma_backoff_pkg::*;
#(
    parameter logic [7:0]  SR_BASE   = 8'd8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic           clk,
    input logic           rst,
    csma_backoff_if.slave bus
);

    logic        enable_q;
    logic [15:0] ifs_q, slot_q;
    logic [3:0]  cw_min_q, cw_max_q, max_retry_q;

    state_e      state_q, state_d;
    logic [3:0]  cw_q, cw_d;
    logic [3:0]  retry_q, retry_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [15:0] slot_cnt_q, slot_cnt_d;
    logic [15:0] remain_q, remain_d;
    logic        tx_grant_q, tx_drop_q, drop_d;

    logic [15:0] lfsr;
    logic        wr_ctrl, wr_timing, wr_cw;
    logic [3:0]  cw_max_eff, cw_inc;
    logic [4:0]  retry_inc;
    logic [16:0] idle_next, slot_next;

    csma_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .value(lfsr)
    );

    assign wr_ctrl   = bus.set_stb_user && (bus.set_addr_user == SR_BASE + RegCtrl);
    assign wr_timing = bus.set_stb_user && (bus.set_addr_user == SR_BASE + RegTiming);
    assign wr_cw     = bus.set_stb_user && (bus.set_addr_user == SR_BASE + RegCw);

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q    <= 1'b0;
            ifs_q       <= 16'd0;
            slot_q      <= 16'd0;
            cw_min_q    <= 4'd0;
            cw_max_q    <= 4'd0;
            max_retry_q <= 4'd0;
        end else begin
            if (wr_ctrl) enable_q <= bus.set_data_user[0];
            if (wr_timing) begin
                ifs_q  <= bus.set_data_user[15:0];
                slot_q <= bus.set_data_user[31:16];
            end
            if (wr_cw) begin
                cw_min_q    <= bus.set_data_user[3:0];
                cw_max_q    <= bus.set_data_user[7:4];
                max_retry_q <= bus.set_data_user[11:8];
            end
        end
    end

    assign cw_max_eff = (cw_max_q < cw_min_q) ? cw_min_q : cw_max_q;
    assign cw_inc     = (cw_q >= cw_max_eff) ? cw_max_eff : cw_q + 4'd1;
    assign retry_inc  = {1'b0, retry_q} + 5'd1;
    assign idle_next  = {1'b0, idle_cnt_q} + 17'd1;
    assign slot_next  = {1'b0, slot_cnt_q} + 17'd1;

    always_comb begin
        state_d    = state_q;
        cw_d       = cw_q;
        retry_d    = retry_q;
        idle_cnt_d = idle_cnt_q;
        slot_cnt_d = slot_cnt_q;
        remain_d   = remain_q;
        drop_d     = 1'b0;

        // Reprogramming the window restarts contention from the new minimum.
        if (wr_cw) cw_d = bus.set_data_user[3:0];

        case (state_q)
            StIdle: begin
                if (bus.tx_req) begin
                    idle_cnt_d = 16'd0;
                    slot_cnt_d = 16'd0;
                    if (enable_q) begin
                        state_d  = StDefer;
                        remain_d = lfsr & cw_mask(cw_q);
                    end else begin
                        state_d = StGrant;
                    end
                end
            end
            StDefer: begin
                if (!bus.tx_req) begin
                    state_d = StIdle;
                end else if (bus.present) begin
                    idle_cnt_d = 16'd0;
                end else if (idle_next >= {1'b0, ifs_q}) begin
                    state_d    = StBackoff;
                    idle_cnt_d = 16'd0;
                    slot_cnt_d = 16'd0;
                end else begin
                    idle_cnt_d = idle_next[15:0];
                end
            end
            StBackoff: begin
                if (!bus.tx_req) begin
                    state_d = StIdle;
                end else if (bus.present) begin
                    // Remaining slots stay frozen; only the partial slot is lost.
                    state_d    = StDefer;
                    idle_cnt_d = 16'd0;
                    slot_cnt_d = 16'd0;
                end else if (remain_q == 16'd0) begin
                    state_d = StGrant;
                end else if (slot_next >= {1'b0, slot_q}) begin
                    slot_cnt_d = 16'd0;
                    remain_d   = remain_q - 16'd1;
                    if (remain_q == 16'd1) state_d = StGrant;
                end else begin
                    slot_cnt_d = slot_next[15:0];
                end
            end
            StGrant: begin
                if (bus.tx_done) begin
                    if (bus.tx_ok || !enable_q) begin
                        cw_d    = cw_min_q;
                        retry_d = 4'd0;
                        state_d = StIdle;
                    end else if (retry_inc > {1'b0, max_retry_q}) begin
                        drop_d  = 1'b1;
                        cw_d    = cw_min_q;
                        retry_d = 4'd0;
                        state_d = StIdle;
                    end else begin
                        retry_d    = retry_inc[3:0];
                        cw_d       = cw_inc;
                        state_d    = StDefer;
                        remain_d   = lfsr & cw_mask(cw_inc);
                        idle_cnt_d = 16'd0;
                        slot_cnt_d = 16'd0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cw_q       <= 4'd0;
            retry_q    <= 4'd0;
            idle_cnt_q <= 16'd0;
            slot_cnt_q <= 16'd0;
            remain_q   <= 16'd0;
            tx_grant_q <= 1'b0;
            tx_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cw_q       <= cw_d;
            retry_q    <= retry_d;
            idle_cnt_q <= idle_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            remain_q   <= remain_d;
            tx_grant_q <= (state_d == StGrant);
            tx_drop_q  <= drop_d;
        end
    end

    assign bus.tx_grant  = tx_grant_q;
    assign bus.tx_drop   = tx_drop_q;
    assign bus.state_out = state_q;

endmodule
